clk_edge_meter: RTL and testbench

Consumer-side companion to the system clock divider. Samples a slow divided clock (e.g. the CPU clock) asynchronously in the fast board-clock domain and synchronizes it. It emits a one-cycle pulse per rising edge and measures each period in fast-clock cycles. It also flags a stalled clock. Used by debug/display logic to step with the CPU clock and to confirm which divider tap is selected.

---
 rtl/clk_edge_meter.sv | 96 +++++++++
 tb/tb_clk_edge_meter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_edge_meter.sv
// Synchronizes a slow clock into the fast clk domain, pulses on each of its rising edges,
// measures the interval between consecutive edges in clk cycles and flags a stopped clock.
module clk_edge_meter #(
  parameter int          CNT_W   = 32,
  parameter int unsigned TIMEOUT = 2**28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             stalled,
  output logic [15:0]      edge_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, STALLED} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic             det;
  logic             at_limit;
  logic [CNT_W-1:0] cnt;

  assign det      = s2 & ~s3;
  assign at_limit = (cnt == CNT_MAX);

  // s1/s2 form the metastability chain; s3 only delays s2 for edge detection.
  // cnt counts cycles since the last edge and parks at the timeout value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s3  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= clk_in;
      s2 <= s1;
      s3 <= s2;
      if (det)
        cnt <= '0;
      else if (!at_limit)
        cnt <= cnt + 1'b1;
    end
  end

  // An edge always beats a simultaneous timeout; only an edge seen while
  // measuring closes a valid interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      edge_pulse   <= 1'b0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
      period       <= '0;
      edge_count   <= '0;
    end else begin
      edge_pulse   <= det;
      period_valid <= 1'b0;
      if (det)
        edge_count <= edge_count + 16'd1;
      case (state)
        IDLE: begin
          if (det) begin
            state <= MEASURE;
          end else if (at_limit) begin
            state   <= STALLED;
            stalled <= 1'b1;
          end
        end
        MEASURE: begin
          if (det) begin
            period       <= cnt + 1'b1;
            period_valid <= 1'b1;
          end else if (at_limit) begin
            state   <= STALLED;
            stalled <= 1'b1;
          end
        end
        STALLED: begin
          if (det) begin
            state   <= MEASURE;
            stalled <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          stalled <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_edge_meter.sv
// Bench for clk_edge_meter: fixed vector table, corner sequences and random clk_in phases,
// all checked every cycle against an edge-timestamp model.
module tb_clk_edge_meter;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clk_in = 1'b0;
  logic             edge_pulse;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             stalled;
  logic [15:0]      edge_count;

  clk_edge_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_in       (clk_in),
    .edge_pulse   (edge_pulse),
    .period       (period),
    .period_valid (period_valid),
    .stalled      (stalled),
    .edge_count   (edge_count)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Model: samples of clk_in at each clk edge since reset, and the edge times of visible pulses.
  bit samp[$];
  int m_idx;
  int last_pulse;
  bit have_pulse;
  bit exp_pulse, exp_valid, exp_stalled;
  int exp_period, exp_count;
  int pulses_seen, valids_seen;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      if (mismatched <= 30)
        $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    samp.delete();
    m_idx       = 0;
    last_pulse  = 0;
    have_pulse  = 1'b0;
    exp_pulse   = 1'b0;
    exp_valid   = 1'b0;
    exp_stalled = 1'b0;
    exp_period  = 0;
    exp_count   = 0;
  endtask

  function automatic bit x_at(input int k);
    return (k >= 1) ? samp[k-1] : 1'b0;
  endfunction

  // A rise sampled at edge k is visible on the outputs after edge k+2.
  task automatic model_step(input bit v);
    bit rise;
    samp.push_back(v);
    m_idx++;
    rise      = x_at(m_idx - 2) && !x_at(m_idx - 3);
    exp_pulse = rise;
    exp_valid = 1'b0;
    if (rise) begin
      if (have_pulse && (m_idx - last_pulse <= TIMEOUT)) begin
        exp_valid  = 1'b1;
        exp_period = m_idx - last_pulse;
      end
      exp_count   = (exp_count + 1) % 65536;
      last_pulse  = m_idx;
      have_pulse  = 1'b1;
      exp_stalled = 1'b0;
    end else begin
      exp_stalled = (m_idx - last_pulse >= TIMEOUT);
    end
  endtask

  // Called at a negedge: drive clk_in, take one clk edge, compare at the next negedge.
  task automatic apply_stimulus(input bit v);
    clk_in = v;
    @(posedge clk);
    model_step(v);
    @(negedge clk);
    check_output("edge_pulse", edge_pulse, exp_pulse);
    check_output("period_valid", period_valid, exp_valid);
    check_output("period", period, exp_period);
    check_output("stalled", stalled, exp_stalled);
    check_output("edge_count", edge_count, exp_count);
    pulses_seen += int'(edge_pulse);
    valids_seen += int'(period_valid);
  endtask

  task automatic run_phases(input int low_len, input int high_len, input int rises);
    for (int r = 0; r < rises; r++) begin
      repeat (low_len) apply_stimulus(1'b0);
      repeat (high_len) apply_stimulus(1'b1);
    end
  endtask

  task automatic do_reset(input bit level);
    @(negedge clk);
    rst    = 1'b1;
    clk_in = level;
    @(negedge clk);
    check_output("reset edge_pulse", edge_pulse, 0);
    check_output("reset period_valid", period_valid, 0);
    check_output("reset period", period, 0);
    check_output("reset stalled", stalled, 0);
    check_output("reset edge_count", edge_count, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    pulses_seen = 0;
    valids_seen = 0;
  endtask

  typedef struct {
    int low_len;
    int high_len;
    int rises;
    int exp_period;
    int exp_count;
    int exp_valids;
    bit exp_stalled;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{4, 4, 5, 8, 5, 4, 1'b0};
    vecs[1] = '{10, 10, 3, 20, 3, 2, 1'b0};
    vecs[2] = '{2, 2, 6, 4, 6, 5, 1'b0};
    vecs[3] = '{3, 5, 4, 8, 4, 3, 1'b0};
    vecs[4] = '{60, 40, 2, 100, 2, 1, 1'b0};
    vecs[5] = '{70, 40, 2, 0, 2, 0, 1'b0};

    for (int i = 0; i < 6; i++) begin
      do_reset(1'b0);
      run_phases(vecs[i].low_len, vecs[i].high_len, vecs[i].rises);
      repeat (4) apply_stimulus(1'b0);
      check_output($sformatf("vec%0d period", i), period, vecs[i].exp_period);
      check_output($sformatf("vec%0d edge_count", i), edge_count, vecs[i].exp_count);
      check_output($sformatf("vec%0d valids", i), valids_seen, vecs[i].exp_valids);
      check_output($sformatf("vec%0d stalled", i), stalled, vecs[i].exp_stalled);
    end

    // clk_in high through reset release: one pulse, then a stall.
    do_reset(1'b1);
    repeat (150) apply_stimulus(1'b1);
    check_output("hold_high pulses", pulses_seen, 1);
    check_output("hold_high stalled", stalled, 1);

    // Stall after period 16, recovery without a period update, then a fresh measurement.
    do_reset(1'b0);
    run_phases(8, 8, 3);
    repeat (120) apply_stimulus(1'b0);
    check_output("stall stalled", stalled, 1);
    check_output("stall period", period, 16);
    valids_seen = 0;
    run_phases(0, 8, 1);
    run_phases(8, 8, 1);
    repeat (4) apply_stimulus(1'b0);
    check_output("recover stalled", stalled, 0);
    check_output("recover valids", valids_seen, 1);
    check_output("recover period", period, 16);

    // Period change 8 -> 20 mid-stream.
    do_reset(1'b0);
    run_phases(4, 4, 5);
    run_phases(10, 10, 5);
    repeat (4) apply_stimulus(1'b0);
    check_output("change period", period, 20);
    check_output("change valids", valids_seen, pulses_seen - 1);

    // Asynchronous reset between clock edges while measuring.
    do_reset(1'b0);
    run_phases(3, 3, 10);
    #2 rst = 1'b1;
    #1;
    check_output("async edge_pulse", edge_pulse, 0);
    check_output("async period_valid", period_valid, 0);
    check_output("async period", period, 0);
    check_output("async stalled", stalled, 0);
    check_output("async edge_count", edge_count, 0);
    clk_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    pulses_seen = 0;
    valids_seen = 0;
    run_phases(3, 3, 1);
    repeat (3) apply_stimulus(1'b0);
    check_output("post_async first pulses", pulses_seen, 1);
    check_output("post_async first valids", valids_seen, 0);
    run_phases(0, 3, 1);
    repeat (3) apply_stimulus(1'b0);
    check_output("post_async second period", period, 6);
    check_output("post_async second valids", valids_seen, 1);

    // Random phase lengths, occasionally long enough to straddle the timeout.
    do_reset(1'b0);
    for (int p = 0; p < 250; p++) begin
      int low_len;
      int high_len;
      low_len  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(85, 115)) : int'($urandom_range(2, 12));
      high_len = int'($urandom_range(2, 12));
      run_phases(low_len, high_len, 1);
    end
    repeat (4) apply_stimulus(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
